// File: rtl/registro_universal_if.sv
// Bus bundle for registro_universal: control/data inputs and registered status outputs.
interface registro_universal_if #(
  parameter int WIDTH = 8
);
  logic             ENA;
  logic [2:0]       OP;
  logic [WIDTH-1:0] D;
  logic             SIN;
  logic             UNDO;
  logic [WIDTH-1:0] Q;
  logic             CO;
  logic             Z;
  logic             UNDO_VLD;

  modport master (
    output ENA, OP, D, SIN, UNDO,
    input  Q, CO, Z, UNDO_VLD
  );

  modport slave (
    input  ENA, OP, D, SIN, UNDO,
    output Q, CO, Z, UNDO_VLD
  );
endinterface

// File: rtl/registro_universal.sv
// Universal register: load, shift, rotate, inc/dec with carry flag and one-deep undo.
module registro_universal #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input logic                 CLK,
  input logic                 RST,
  registro_universal_if.slave bus
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } op_e;

  op_e              op_sel;
  logic [WIDTH-1:0] q_r, q_nx;
  logic [WIDTH-1:0] sh_r, sh_nx;
  logic             co_r, co_nx;
  logic             vld_r, vld_nx;
  logic             z_r;
  logic             take_undo;

  assign op_sel = op_e'(bus.OP);

  always_comb begin
    q_nx      = q_r;
    sh_nx     = sh_r;
    co_nx     = co_r;
    vld_nx    = vld_r;
    take_undo = bus.ENA && bus.UNDO && vld_r;
    if (take_undo) begin
      q_nx   = sh_r;
      co_nx  = 1'b0;
      vld_nx = 1'b0;
    end else if (bus.ENA && op_sel != OP_HOLD) begin
      sh_nx  = q_r;
      vld_nx = 1'b1;
      unique case (op_sel)
        OP_HOLD: ;
        OP_LOAD: begin
          q_nx  = bus.D;
          co_nx = 1'b0;
        end
        OP_SHL: begin
          q_nx  = {q_r[WIDTH-2:0], bus.SIN};
          co_nx = q_r[WIDTH-1];
        end
        OP_SHR: begin
          q_nx  = {bus.SIN, q_r[WIDTH-1:1]};
          co_nx = q_r[0];
        end
        OP_ROL: begin
          q_nx  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          co_nx = q_r[WIDTH-1];
        end
        OP_ROR: begin
          q_nx  = {q_r[0], q_r[WIDTH-1:1]};
          co_nx = q_r[0];
        end
        OP_INC: {co_nx, q_nx} = {1'b0, q_r} + (WIDTH+1)'(1);
        OP_DEC: begin
          q_nx  = q_r - WIDTH'(1);
          co_nx = (q_r == '0);
        end
      endcase
    end
  end

  // Z is registered from the next-state value so it tracks Q with no extra lag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r   <= RST_VAL;
      sh_r  <= RST_VAL;
      co_r  <= 1'b0;
      vld_r <= 1'b0;
      z_r   <= (RST_VAL == '0);
    end else begin
      q_r   <= q_nx;
      sh_r  <= sh_nx;
      co_r  <= co_nx;
      vld_r <= vld_nx;
      z_r   <= (q_nx == '0);
    end
  end

  assign bus.Q        = q_r;
  assign bus.CO       = co_r;
  assign bus.Z        = z_r;
  assign bus.UNDO_VLD = vld_r;

endmodule

// File: tb/tb_registro_universal.sv
// Bench for registro_universal at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_registro_universal;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  registro_universal_if #(.WIDTH(8))  b8();
  registro_universal_if #(.WIDTH(16)) b16();

  registro_universal #(.WIDTH(8))  dut8  (.CLK(CLK), .RST(RST), .bus(b8.slave));
  registro_universal #(.WIDTH(16)) dut16 (.CLK(CLK), .RST(RST), .bus(b16.slave));

  typedef struct {
    longint unsigned q;
    longint unsigned sh;
    bit              co;
    bit              vld;
  } mdl_t;

  mdl_t m8, m16;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mreset(input int unsigned w);
    mdl_t s;
    s.q   = 64'd1 << (w - 1);
    s.sh  = s.q;
    s.co  = 1'b0;
    s.vld = 1'b0;
    return s;
  endfunction

  function automatic mdl_t mstep(input int unsigned w, input mdl_t s, input bit ena,
                                 input bit [2:0] op, input longint unsigned d,
                                 input bit sin, input bit undo);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned top  = 64'd1 << (w - 1);
    bit              msb  = (s.q & top) != 0;
    bit              lsb  = (s.q & 1) != 0;
    mdl_t            n    = s;
    if (!ena) return n;
    if (undo && s.vld) begin
      n.q   = s.sh;
      n.co  = 1'b0;
      n.vld = 1'b0;
      return n;
    end
    if (op == 3'd0) return n;
    n.sh  = s.q;
    n.vld = 1'b1;
    case (op)
      3'd1: begin n.q = d & mask;                              n.co = 1'b0; end
      3'd2: begin n.q = ((s.q * 2) + sin) & mask;              n.co = msb;  end
      3'd3: begin n.q = (s.q / 2) + (sin ? top : 0);           n.co = lsb;  end
      3'd4: begin n.q = ((s.q * 2) + msb) & mask;              n.co = msb;  end
      3'd5: begin n.q = (s.q / 2) + (lsb ? top : 0);           n.co = lsb;  end
      3'd6: begin n.q = (s.q == mask) ? 0 : s.q + 1;           n.co = (s.q == mask); end
      default: begin n.q = (s.q == 0) ? mask : s.q - 1;       n.co = (s.q == 0);    end
    endcase
    return n;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/q8"},    b8.Q,         m8.q);
    check({tag, "/co8"},   b8.CO,        m8.co);
    check({tag, "/z8"},    b8.Z,         m8.q == 0);
    check({tag, "/vld8"},  b8.UNDO_VLD,  m8.vld);
    check({tag, "/q16"},   b16.Q,        m16.q);
    check({tag, "/co16"},  b16.CO,       m16.co);
    check({tag, "/z16"},   b16.Z,        m16.q == 0);
    check({tag, "/vld16"}, b16.UNDO_VLD, m16.vld);
  endtask

  task automatic drive(input string tag, input bit ena, input bit [2:0] op,
                       input longint unsigned d, input bit sin, input bit undo);
    b8.ENA = ena;  b8.OP = op;  b8.D = d[7:0];   b8.SIN = sin;  b8.UNDO = undo;
    b16.ENA = ena; b16.OP = op; b16.D = d[15:0]; b16.SIN = sin; b16.UNDO = undo;
    @(posedge CLK);
    m8  = mstep(8,  m8,  ena, op, d, sin, undo);
    m16 = mstep(16, m16, ena, op, d, sin, undo);
    #1;
    check_all(tag);
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge arrives.
  task automatic async_reset(input string tag);
    #3 RST = 1'b1;
    #1;
    m8  = mreset(8);
    m16 = mreset(16);
    check_all(tag);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  localparam longint unsigned ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    RST = 1'b1;
    b8.ENA = 1'b0;  b8.OP = '0;  b8.D = '0;  b8.SIN = 1'b0;  b8.UNDO = 1'b0;
    b16.ENA = 1'b0; b16.OP = '0; b16.D = '0; b16.SIN = 1'b0; b16.UNDO = 1'b0;
    m8  = mreset(8);
    m16 = mreset(16);
    #12;
    check_all("reset");
    check("reset_q8", b8.Q, 64'h80);
    check("reset_q16", b16.Q, 64'h8000);
    @(negedge CLK);
    RST = 1'b0;

    // shifts and rotates from the reset value
    drive("shl", 1, 3'd2, 0, 1, 0);
    check("shl_q8", b8.Q, 64'h01);    check("shl_co8", b8.CO, 1);
    check("shl_q16", b16.Q, 64'h0001); check("shl_co16", b16.CO, 1);
    drive("ror", 1, 3'd5, 0, 0, 0);
    check("ror_q8", b8.Q, 64'h80);    check("ror_co8", b8.CO, 1);
    drive("shr", 1, 3'd3, 0, 0, 0);
    check("shr_q8", b8.Q, 64'h40);    check("shr_co8", b8.CO, 0);
    check("shr_q16", b16.Q, 64'h4000);

    // increment wrap followed by undo and a second, ineffective undo
    drive("ld_ones", 1, 3'd1, ONES, 0, 0);
    drive("inc_wrap", 1, 3'd6, 0, 0, 0);
    check("inc_q8", b8.Q, 0);  check("inc_co8", b8.CO, 1);
    check("inc_z8", b8.Z, 1);  check("inc_vld8", b8.UNDO_VLD, 1);
    check("inc_q16", b16.Q, 0); check("inc_co16", b16.CO, 1);
    drive("undo", 1, 3'd0, 0, 0, 1);
    check("undo_q8", b8.Q, 64'hFF); check("undo_co8", b8.CO, 0);
    check("undo_vld8", b8.UNDO_VLD, 0); check("undo_q16", b16.Q, 64'hFFFF);
    drive("undo2", 1, 3'd0, 0, 0, 1);
    check("undo2_q8", b8.Q, 64'hFF); check("undo2_vld8", b8.UNDO_VLD, 0);

    // decrement wrap
    drive("ld_zero", 1, 3'd1, 0, 0, 0);
    check("ldz_z8", b8.Z, 1);
    drive("dec_wrap", 1, 3'd7, 0, 0, 0);
    check("dec_q8", b8.Q, 64'hFF); check("dec_co8", b8.CO, 1); check("dec_z8", b8.Z, 0);

    // enable gating
    for (int i = 0; i < 3; i++) drive("ena_off", 0, 3'd1, 64'h55, 1, 1);
    check("gate_q8", b8.Q, 64'hFF); check("gate_vld8", b8.UNDO_VLD, 1);

    // asynchronous reset mid-cycle after a load
    drive("ld_3c", 1, 3'd1, 64'h3C, 0, 0);
    async_reset("mid_rst");
    check("rst_q8", b8.Q, 64'h80); check("rst_co8", b8.CO, 0);
    check("rst_z8", b8.Z, 0);      check("rst_vld8", b8.UNDO_VLD, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        drive("rnd", $urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) < 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
